// File: rtl/uart_recv_pkg.sv
// uart_recv_pkg: definitions shared by the UART receive/transmit path.
//   - default clock and line rate
//   - 3-bit receiver state encoding (PARITY only exists with UART_RECV_PARITY_EN)
//   - clock-cycles-per-bit helper (integer-truncated CLK_HZ/BAUD)
package uart_recv_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 12000000;
  localparam int unsigned DEFAULT_BAUD   = 115200;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RECV_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_recv_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL (1 for an idle-high UART line).
// Ports:
//   clk_i  in  1  clock
//   rst_i  in  1  synchronous active-high reset
//   d_i    in  1  asynchronous input
//   q_o    out 1  synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_recv.sv
// uart_recv: UART receiver, 8N1 (or 8E1 with UART_RECV_PARITY_EN defined).
// Ports:
//   CLK         in  1  system clock, rising edge
//   rst         in  1  synchronous active-high reset
//   rx          in  1  asynchronous serial line, idles high
//   data        out 8  last good byte, held until the next good byte
//   valid       out 1  one-cycle pulse, data is new
//   frame_err   out 1  one-cycle pulse, stop bit sampled low
//   parity_err  out 1  one-cycle pulse, parity mismatch (0 without the macro)
//   busy        out 1  high while a frame is in progress (incl. strobe cycle)
// Optional feature macro: UART_RECV_PARITY_EN (even parity bit after data).
module uart_recv
  import uart_recv_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD   = DEFAULT_BAUD
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  // Counters count down to zero and sample on the zero cycle, so loads are N-1.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rxs;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             busy_q;
`ifdef UART_RECV_PARITY_EN
  logic             par_bad_q;
  logic             par_err_q;
`endif

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i(CLK),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rxs)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state_q)
        // busy follows the start detection; stays low otherwise, which also
        // ends the strobe cycle's busy after a completed frame.
        ST_IDLE: begin
          if (!rxs) begin
            cnt_q   <= HALF_LOAD;
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rxs) begin
            cnt_q   <= BIT_LOAD;
            bit_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rxs, shift_q[7:1]};
            cnt_q   <= BIT_LOAD;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RECV_PARITY_EN
        ST_PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            par_bad_q <= (rxs != ^shift_q);
            cnt_q     <= BIT_LOAD;
            state_q   <= ST_STOP;
          end
        end
`endif
        // Completion returns to IDLE in the strobe cycle with busy still high,
        // so a back-to-back start edge is caught on the very next cycle.
        ST_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs) begin
            state_q <= ST_IDLE;
`ifdef UART_RECV_PARITY_EN
            if (par_bad_q) begin
              par_err_q <= 1'b1;
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
`else
            data_q  <= shift_q;
            valid_q <= 1'b1;
`endif
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= ST_WAIT_HIGH;
          end
        end
        // A held-low line (break) must not be re-read as 0x00 frames.
        ST_WAIT_HIGH: begin
          if (rxs) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RECV_PARITY_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
